// File: rtl/wb_host_master_pkg.sv
// Shared definitions for the host-side Wishbone master: FSM encoding,
// the abort read value and the register offsets that bring-up code pokes.
package wb_host_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

   localparam logic [31:0] BAD_FAB_AC            = 32'hBADFABAC;
   localparam logic [31:0] DEF_TIMEOUT_RD_VALUE  = BAD_FAB_AC;

   // Word offsets seen by the slave decoder on WBs_ADR[ADDRWIDTH_FAB_REG+1:2]
   localparam int          ADDRWIDTH_FAB_REG     = 7;
   localparam logic [6:0]  REG_ID                = 7'h00;
   localparam logic [6:0]  REG_MULT1_A           = 7'h04;
   localparam logic [6:0]  REG_QL_REV            = 7'h7F;

endpackage

// File: rtl/wb_host_master_ack_timer.sv
// Loadable up-counter that flags when the ACK wait has reached its last cycle.
module wb_ack_timer #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TC_VALUE = 8'd254
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tc = (cnt_q == TC_VALUE);

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone master: turns a valid/ready command stream into
// one bus cycle at a time and reports data or an error on a response stream.
module wb_host_master
   import wb_host_master_pkg::*;
#(
   parameter int                   ADDRWIDTH          = 17,
   parameter int                   DATAWIDTH          = 32,
   parameter int                   TIMEOUT_CNTR_WIDTH = 8,
   parameter int                   TIMEOUT_CYCLES     = 255,
   parameter logic [DATAWIDTH-1:0] TIMEOUT_RD_VALUE   = DATAWIDTH'(DEF_TIMEOUT_RD_VALUE)
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [ADDRWIDTH-1:0] cmd_adr_i,
   input  logic [3:0]           cmd_byte_stb_i,
   input  logic [DATAWIDTH-1:0] cmd_wr_dat_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DATAWIDTH-1:0] rsp_rd_dat_o,
   output logic                 rsp_err_o,
   output logic [ADDRWIDTH-1:0] WBs_ADR,
   output logic                 WBs_CYC,
   output logic                 WBs_STB,
   output logic                 WBs_WE,
   output logic                 WBs_RD,
   output logic [3:0]           WBs_BYTE_STB,
   output logic [DATAWIDTH-1:0] WBs_WR_DAT,
   input  logic [DATAWIDTH-1:0] WBs_RD_DAT,
   input  logic                 WBs_ACK,
   output logic                 busy_o
);

   wb_state_e              state_q, state_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic [ADDRWIDTH-1:0]   adr_q, adr_d;
   logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, rd_q, rd_d;
   logic [3:0]             bstb_q, bstb_d;
   logic [DATAWIDTH-1:0]   wdat_q, wdat_d;
   logic                   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [DATAWIDTH-1:0]   rsp_dat_q, rsp_dat_d;
   logic                   busy_q;
   logic                   timer_load, timer_tc;

   wb_ack_timer #(
      .WIDTH    (TIMEOUT_CNTR_WIDTH),
      .TC_VALUE (TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1))
   ) u_ack_timer (
      .clk  (WB_CLK),
      .rst  (WB_RST),
      .load (timer_load),
      .en   (state_q == ST_BUS),
      .tc   (timer_tc)
   );

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         adr_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         rd_q        <= 1'b0;
         bstb_q      <= '0;
         wdat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         adr_q       <= adr_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         rd_q        <= rd_d;
         bstb_q      <= bstb_d;
         wdat_q      <= wdat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = 1'b0;
      adr_d       = adr_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      rd_d        = rd_q;
      bstb_d      = bstb_q;
      wdat_d      = wdat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      timer_load  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            // cmd_ready_q gates acceptance so nothing is taken in the first cycle out of reset
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               timer_load  = 1'b1;
               if (cmd_we_i && (cmd_byte_stb_i == 4'h0)) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_dat_d   = '0;
               end else begin
                  state_d = ST_BUS;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  adr_d   = cmd_adr_i;
                  we_d    = cmd_we_i;
                  rd_d    = ~cmd_we_i;
                  bstb_d  = cmd_we_i ? cmd_byte_stb_i : 4'hF;
                  wdat_d  = cmd_we_i ? cmd_wr_dat_i : '0;
               end
            end
         end
         ST_BUS: begin
            // ACK takes priority over a timeout landing in the same cycle
            if (WBs_ACK || timer_tc) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rd_d        = 1'b0;
               bstb_d      = 4'h0;
               rsp_valid_d = 1'b1;
               timer_load  = 1'b1;
               if (WBs_ACK) begin
                  rsp_err_d = 1'b0;
                  rsp_dat_d = we_q ? '0 : WBs_RD_DAT;
               end else begin
                  rsp_err_d = 1'b1;
                  rsp_dat_d = TIMEOUT_RD_VALUE;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready_o  = cmd_ready_q;
   assign WBs_ADR      = adr_q;
   assign WBs_CYC      = cyc_q;
   assign WBs_STB      = stb_q;
   assign WBs_WE       = we_q;
   assign WBs_RD       = rd_q;
   assign WBs_BYTE_STB = bstb_q;
   assign WBs_WR_DAT   = wdat_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_rd_dat_o = rsp_dat_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a small word-addressed slave model.
module tb_wb_host_master;

   localparam int AW = 17;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [3:0]    cmd_bs = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic          cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o;
   logic [DW-1:0] rsp_rd_dat_o;
   logic [AW-1:0] WBs_ADR;
   logic          WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ACK;
   logic [3:0]    WBs_BYTE_STB;
   logic [DW-1:0] WBs_WR_DAT, WBs_RD_DAT;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_host_master #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
      .WB_CLK(clk), .WB_RST(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_byte_stb_i(cmd_bs), .cmd_wr_dat_i(cmd_dat),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
      .rsp_rd_dat_o(rsp_rd_dat_o), .rsp_err_o(rsp_err_o),
      .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
      .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
      .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK), .busy_o(busy_o)
   );

   // Slave model: ACKs after ack_wait bus cycles when enabled, byte-lane writes
   logic          ack_en = 1'b0, force_ack = 1'b0;
   int            ack_wait = 0;
   int            wcnt;
   logic [31:0]   mem [0:127];
   logic [31:0]   wtmp;

   assign WBs_ACK    = force_ack | (ack_en & WBs_CYC & WBs_STB & (wcnt == ack_wait));
   assign WBs_RD_DAT = mem[WBs_ADR[8:2]];

   always @(posedge clk) begin
      if (rst) begin
         wcnt <= 0;
         for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
         mem[0]   <= 32'hC0FFEE01;
         mem[127] <= 32'h00010000;
      end else begin
         wcnt <= (WBs_CYC & WBs_STB & ~WBs_ACK) ? wcnt + 1 : 0;
         if (WBs_CYC & WBs_ACK & WBs_WE) begin
            wtmp = mem[WBs_ADR[8:2]];
            for (int b = 0; b < 4; b++)
               if (WBs_BYTE_STB[b]) wtmp[8*b +: 8] = WBs_WR_DAT[8*b +: 8];
            mem[WBs_ADR[8:2]] <= wtmp;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic we, input logic [AW-1:0] adr,
                       input logic [3:0] bs, input logic [DW-1:0] dat);
      int n;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_bs = bs; cmd_dat = dat;
      n = 0;
      while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
      if (!cmd_ready_o) chk("cmd_accept_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output int lat, output logic [DW-1:0] d,
                          output logic e, output logic c);
      lat = 0;
      while (!rsp_valid_o && lat < 400) begin @(negedge clk); lat++; end
      d = rsp_rd_dat_o; e = rsp_err_o; c = WBs_CYC;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [3:0]    bs;
      logic [DW-1:0] dat;
      logic          ack_en;
      int            ack_wait;
      logic [DW-1:0] exp_dat;
      logic          exp_err;
      int            exp_lat;
   } vec_t;

   vec_t          vecs [9];
   int            lat;
   logic [DW-1:0] rd, held;
   logic          er, cy;
   logic          legal;

   initial begin
      vecs[0] = '{1'b1, 17'h00010, 4'hF, 32'h12345678, 1'b1,   2, 32'h00000000, 1'b0,   3};
      vecs[1] = '{1'b0, 17'h00010, 4'h0, 32'h00000000, 1'b1,   0, 32'h12345678, 1'b0,   1};
      vecs[2] = '{1'b0, 17'h011FC, 4'h0, 32'h00000000, 1'b1,   0, 32'h00010000, 1'b0,   1};
      vecs[3] = '{1'b1, 17'h00010, 4'h3, 32'hAAAA5555, 1'b1,   1, 32'h00000000, 1'b0,   2};
      vecs[4] = '{1'b0, 17'h00010, 4'h0, 32'h00000000, 1'b1,   0, 32'h12345555, 1'b0,   1};
      vecs[5] = '{1'b1, 17'h00020, 4'h0, 32'hDEADBEEF, 1'b1,   0, 32'h00000000, 1'b1,   0};
      vecs[6] = '{1'b0, 17'h02000, 4'h0, 32'h00000000, 1'b0,   0, 32'hBADFABAC, 1'b1, 255};
      vecs[7] = '{1'b1, 17'h02004, 4'hF, 32'h55AA55AA, 1'b0,   0, 32'hBADFABAC, 1'b1, 255};
      vecs[8] = '{1'b0, 17'h00000, 4'h0, 32'h00000000, 1'b1, 254, 32'hC0FFEE01, 1'b0, 255};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {cmd_ready_o, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB,
                         rsp_valid_o, rsp_err_o, busy_o}, 0);
      chk("reset_data", {rsp_rd_dat_o, WBs_WR_DAT}, 0);
      chk("reset_adr", WBs_ADR, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", cmd_ready_o, 1);

      for (int i = 0; i < 9; i++) begin
         ack_en = vecs[i].ack_en; ack_wait = vecs[i].ack_wait;
         legal = !(vecs[i].we && vecs[i].bs == 4'h0);
         send(vecs[i].we, vecs[i].adr, vecs[i].bs, vecs[i].dat);
         if (legal) begin
            chk($sformatf("v%0d_cyc_stb", i), {WBs_CYC, WBs_STB}, 2'b11);
            chk($sformatf("v%0d_we_rd", i), {WBs_WE, WBs_RD}, {vecs[i].we, ~vecs[i].we});
            chk($sformatf("v%0d_bstb", i), WBs_BYTE_STB, vecs[i].we ? vecs[i].bs : 4'hF);
            chk($sformatf("v%0d_adr", i), WBs_ADR, vecs[i].adr);
            chk($sformatf("v%0d_wdat", i), WBs_WR_DAT, vecs[i].we ? vecs[i].dat : 32'h0);
            chk($sformatf("v%0d_ready_busy", i), {cmd_ready_o, busy_o}, 2'b01);
         end else begin
            chk($sformatf("v%0d_no_cyc", i), WBs_CYC, 0);
            chk($sformatf("v%0d_rsp_now", i), rsp_valid_o, 1);
         end
         get_rsp(lat, rd, er, cy);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_rsp_dat", i), rd, vecs[i].exp_dat);
         chk($sformatf("v%0d_rsp_err", i), er, vecs[i].exp_err);
         chk($sformatf("v%0d_cyc_low_at_rsp", i), cy, 0);
      end

      // Response backpressure: held 5 cycles with rsp_ready low
      ack_en = 1'b1; ack_wait = 0;
      send(1'b0, 17'h011FC, 4'h0, 32'h0);
      @(negedge clk);
      chk("bp_valid", rsp_valid_o, 1);
      held = rsp_rd_dat_o;
      chk("bp_data", held, 32'h00010000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_ctrl", k), {rsp_valid_o, cmd_ready_o, rsp_err_o}, 3'b100);
         chk($sformatf("bp_hold%0d_dat", k), rsp_rd_dat_o, 32'h00010000);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_consumed", rsp_valid_o, 0);

      // Spurious ACK while idle
      @(negedge clk);
      force_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("spur_ack%0d", k), {rsp_valid_o, busy_o, WBs_CYC, cmd_ready_o}, 4'b0001);
      end
      force_ack = 1'b0;

      // Reset in the middle of a bus cycle
      ack_en = 1'b0;
      send(1'b0, 17'h02000, 4'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("mid_bus_cyc", WBs_CYC, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs", {WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB,
                           rsp_valid_o, busy_o, cmd_ready_o}, 0);
      chk("mid_rst_adr", WBs_ADR, 0);
      rst = 1'b0;
      @(negedge clk);
      ack_en = 1'b1; ack_wait = 1;
      send(1'b0, 17'h011FC, 4'h0, 32'h0);
      get_rsp(lat, rd, er, cy);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_dat", rd, 32'h00010000);
      chk("post_rst_err", er, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Single-outstanding Wishbone master that drives the FPGA IP slave bus (WBs_ADR/CYC/STB/WE/RD/BYTE_STB/WR_DAT) from a simple valid/ready command stream.
- Returns read data or a write completion on a valid/ready response stream.
- Sits directly upstream of the FPGA IP register/reserved-block decoder; used by bring-up logic and the simulation host model.
- Enforces an ACK timeout so that an unmapped or hung slave cannot stall the host.

Parameters:
ADDRWIDTH, 17, byte-address width of WBs_ADR
DATAWIDTH, 32, data bus width
TIMEOUT_CNTR_WIDTH, 8, width of ACK-wait counter
TIMEOUT_CYCLES, 255, bus cycles waited for WBs_ACK before abort (1..2^TIMEOUT_CNTR_WIDTH-1)
TIMEOUT_RD_VALUE, 32'hBAD_FAB_AC, read data returned on timeout or error

Ports:
WB_CLK  in  1  clock
WB_RST  in  1  synchronous active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  ADDRWIDTH  byte address
cmd_byte_stb_i  in  4  write byte enables
cmd_wr_dat_i  in  DATAWIDTH  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rd_dat_o  out  DATAWIDTH  read data (0 for writes)
rsp_err_o  out  1  timeout or illegal command
WBs_ADR  out  ADDRWIDTH  bus address
WBs_CYC  out  1  cycle
WBs_STB  out  1  strobe
WBs_WE  out  1  write enable
WBs_RD  out  1  read enable (= CYC & ~WE)
WBs_BYTE_STB  out  4  byte strobes
WBs_WR_DAT  out  DATAWIDTH  write data
WBs_RD_DAT  in  DATAWIDTH  read data from slave
WBs_ACK  in  1  slave acknowledge
busy_o  out  1  state != IDLE

Behaviour:
- All outputs registered. Reset values: cmd_ready_o=0 during reset, 1 in the first IDLE cycle after reset; every other output 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch the command and go to BUS; CYC/STB high from the next cycle.
  - Legal write (byte_stb != 0): WBs_WE=1, WBs_RD=0, WBs_BYTE_STB=cmd_byte_stb_i.
  - Read: WBs_WE=0, WBs_RD=1, WBs_BYTE_STB=4'hF, WBs_WR_DAT=0.
  - Write with byte_stb==0 is illegal: no bus cycle; go straight to RESP with rsp_err_o=1 and rsp_rd_dat_o=0.
- BUS:
  - Hold all WBs_* stable; cmd_ready_o=0; the counter increments each cycle from 0.
  - WBs_ACK=1: capture WBs_RD_DAT (reads) or 0 (writes), rsp_err_o=0. CYC/STB/WE/RD/BYTE_STB deassert on that edge, so they are low the cycle after ACK. Go to RESP.
  - Counter == TIMEOUT_CYCLES-1 with no ACK: deassert the bus, rsp_err_o=1, rsp_rd_dat_o=TIMEOUT_RD_VALUE (reads and writes). Go to RESP.
  - ACK arriving in the same cycle as the timeout: ACK wins, no error.
- RESP: rsp_valid_o=1 with data and error held stable until rsp_ready_i; then go to IDLE with rsp_valid_o=0.
- No new command is accepted before the response is consumed; exactly one transaction is outstanding.
- Latency: cmd accept at edge N, CYC/STB high from N+1, minimum rsp_valid_o at N+2 with zero-wait ACK.
- WBs_ACK outside BUS is ignored, with no state change and no response.
- WB_RST mid-operation: next edge forces IDLE, all WBs_* low, rsp_valid_o=0, counter 0. The transaction is dropped with no response.
- Address passes through unmodified; bits [1:0] are not forced, and slave decoding uses [ADDRWIDTH_FAB_REG+1:2].

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2).
  - TIMEOUT_RD_VALUE and the default BAD_FAB_AC constant.
  - Bus register offsets used by tests (ID 7'h0, MULT1_A 7'h4, QL revisions 7'h7F).
- Single sub-module wb_ack_timer: loadable counter with a terminal-count pulse. All else stays flat.

Test Plan:
- Write 0x12345678 to 0x00010, byte_stb 4'hF, slave ACKs after 2 cycles -> WE=1, BYTE_STB=4'hF on bus, rsp_valid with err=0, data=0; read back 0x00010 returns 0x12345678.
- Read 0x011FC (QL revisions), zero-wait ACK -> RD=1, rsp_rd_dat=0x00010000, rsp_valid two cycles after accept.
- Read 0x02000 (undecoded) with slave never ACKing -> CYC drops after 255 bus cycles, rsp_err=1, rsp_rd_dat=0xBADFABAC.
- ACK on the exact timeout cycle -> err=0 and real data returned; rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout.
- Write with byte_stb 4'h0 -> no CYC assertion, immediate rsp_err=1; spurious ACK in IDLE -> no response generated.
- WB_RST asserted during BUS -> all WBs_* low and rsp_valid=0 the next cycle; first post-reset command completes normally.
